// File: rtl/flash_resp_pkg.sv
// Shared opcodes, rescue-sequence lengths and FSM encoding for the flash
// command responder.
package flash_resp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CMD     = 2'd1,
        ST_FSR_OUT = 2'd2,
        ST_IGNORE  = 2'd3
    } resp_state_e;

    localparam logic [7:0] OPC_READ_FSR   = 8'h70;

    localparam logic [4:0] RESCUE_P1_LEN_A = 5'd7;
    localparam logic [4:0] RESCUE_P1_LEN_B = 5'd13;
    localparam logic [4:0] RESCUE_P1_LEN_C = 5'd25;
    localparam logic [4:0] RESCUE_P2_LEN   = 5'd8;

    localparam logic [4:0] BIT_CNT_MAX     = 5'd31;

    // Part-1 frames may be any of the three accepted lengths.
    function automatic logic is_part1_len(input logic [4:0] n);
        return (n == RESCUE_P1_LEN_A) || (n == RESCUE_P1_LEN_B) ||
               (n == RESCUE_P1_LEN_C);
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Two-flop synchronizer for one SPI pin plus a third flop for edge detection
// in the system clock domain.
module spi_edge_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_r;
    logic sync_r;
    logic prev_r;

    // Synchronizer chain and previous-level history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= RESET_VAL;
            sync_r <= RESET_VAL;
            prev_r <= RESET_VAL;
        end else begin
            meta_r <= din;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign level = sync_r;
    assign rise  = sync_r & ~prev_r;
    assign fall  = ~sync_r & prev_r;

endmodule

// File: rtl/flash_cmd_responder.sv
// SPI flash command responder: answers Read Flag Status (0x70) and detects the
// all-ones power-loss rescue sequence, which holds the device busy for a while.
module flash_cmd_responder
    import flash_resp_pkg::*;
#(
    parameter int         RESCUE_CYCLES = 2000,
    parameter logic [7:0] FSR_RESET     = 8'h80
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic spi_sck_i,
    input  logic spi_cs_ni,
    input  logic spi_dq0_i,
    output logic spi_dq1_o,
    output logic spi_dq1_oe_o,
    output logic rescue_done_o,
    output logic busy_o
);

    localparam int CNT_W = (RESCUE_CYCLES > 1) ? $clog2(RESCUE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] BUSY_LOAD = CNT_W'(RESCUE_CYCLES - 1);

    logic sck_level_s, sck_rise_s, sck_fall_s;
    logic cs_level_s, cs_rise_s, cs_fall_s;
    logic dq0_s, dq0_rise_s, dq0_fall_s;
    logic unused_s;

    resp_state_e state_r, next_state_s;

    logic [1:0]       warm_r;
    logic             cs_ok_r;
    logic             cs_fall_ok_s;
    logic [7:0]       shift_r;
    logic [7:0]       opcode_s;
    logic [4:0]       bit_cnt_r;
    logic             all_ones_r;
    logic [2:0]       out_idx_r;
    logic             dq1_r;
    logic             dq1_oe_r;
    logic             rescue_armed_r;
    logic             busy_r;
    logic [CNT_W-1:0] busy_cnt_r;
    logic             rescue_done_r;
    logic             fsr_ready_r;
    logic [7:0]       fsr_s;

    logic frame_start_s;
    logic shift_en_s;
    logic frame_end_s;
    logic fsr_shift_s;
    logic dq1_oe_next_s;
    logic p1_hit_s;
    logic p2_hit_s;

    spi_edge_sync #(.RESET_VAL(1'b0)) u_sck_sync (
        .clk(clk_i), .rst(rst_i), .din(spi_sck_i),
        .level(sck_level_s), .rise(sck_rise_s), .fall(sck_fall_s)
    );

    spi_edge_sync #(.RESET_VAL(1'b1)) u_cs_sync (
        .clk(clk_i), .rst(rst_i), .din(spi_cs_ni),
        .level(cs_level_s), .rise(cs_rise_s), .fall(cs_fall_s)
    );

    spi_edge_sync #(.RESET_VAL(1'b0)) u_dq0_sync (
        .clk(clk_i), .rst(rst_i), .din(spi_dq0_i),
        .level(dq0_s), .rise(dq0_rise_s), .fall(dq0_fall_s)
    );

    assign unused_s = ^{sck_level_s, dq0_rise_s, dq0_fall_s};

    assign opcode_s     = {shift_r[6:0], dq0_s};
    assign fsr_s        = {fsr_ready_r, FSR_RESET[6:0]};
    // A CS held low across reset release must not look like a new frame start.
    assign cs_fall_ok_s = cs_fall_s & cs_ok_r;

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cs_fall_ok_s) begin
                    next_state_s = busy_r ? ST_IGNORE : ST_CMD;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_CMD, ST_IGNORE: begin
                if (cs_rise_s) begin
                    next_state_s = ST_IDLE;
                end else if (sck_rise_s && (bit_cnt_r == 5'd7) &&
                             (opcode_s == OPC_READ_FSR)) begin
                    next_state_s = ST_FSR_OUT;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_FSR_OUT: begin
                if (cs_rise_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_FSR_OUT;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // FSM output decode: datapath strobes for the current state.
    always_comb begin
        frame_start_s = 1'b0;
        shift_en_s    = 1'b0;
        frame_end_s   = 1'b0;
        fsr_shift_s   = 1'b0;
        dq1_oe_next_s = (next_state_s == ST_FSR_OUT);
        case (state_r)
            ST_IDLE: begin
                frame_start_s = cs_fall_ok_s;
            end
            ST_CMD, ST_IGNORE: begin
                shift_en_s  = sck_rise_s & ~cs_rise_s;
                frame_end_s = cs_rise_s;
            end
            ST_FSR_OUT: begin
                fsr_shift_s = sck_fall_s & ~cs_rise_s;
            end
            default: begin
                frame_start_s = 1'b0;
            end
        endcase
    end

    assign p1_hit_s = frame_end_s & all_ones_r & is_part1_len(bit_cnt_r);
    assign p2_hit_s = frame_end_s & all_ones_r & rescue_armed_r &
                      (bit_cnt_r == RESCUE_P2_LEN);

    // Waits two clocks after reset, then requires CS seen high before accepting frames.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            warm_r  <= 2'b00;
            cs_ok_r <= 1'b0;
        end else begin
            warm_r <= {warm_r[0], 1'b1};
            if (warm_r[1] && cs_level_s) begin
                cs_ok_r <= 1'b1;
            end
        end
    end

    // Command shift register, saturating bit counter and all-ones tracking.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_r    <= 8'h00;
            bit_cnt_r  <= 5'd0;
            all_ones_r <= 1'b0;
        end else if (frame_start_s) begin
            shift_r    <= 8'h00;
            bit_cnt_r  <= 5'd0;
            all_ones_r <= 1'b1;
        end else if (shift_en_s) begin
            shift_r    <= opcode_s;
            all_ones_r <= all_ones_r & dq0_s;
            if (bit_cnt_r != BIT_CNT_MAX) begin
                bit_cnt_r <= bit_cnt_r + 5'd1;
            end
        end
    end

    // FSR serializer: MSB first on SCK falling edges, wrapping after bit 0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_idx_r <= 3'd7;
            dq1_r     <= 1'b0;
            dq1_oe_r  <= 1'b0;
        end else begin
            dq1_oe_r <= dq1_oe_next_s;
            if (fsr_shift_s) begin
                dq1_r     <= fsr_s[out_idx_r];
                out_idx_r <= out_idx_r - 3'd1;
            end else if (state_r != ST_FSR_OUT) begin
                dq1_r     <= 1'b0;
                out_idx_r <= 3'd7;
            end
        end
    end

    // Rescue arming: only an all-ones part-1 frame leaves it set.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rescue_armed_r <= 1'b0;
        end else if (cs_rise_s && (state_r != ST_IDLE)) begin
            rescue_armed_r <= p1_hit_s;
        end
    end

    // Busy period countdown; a repeated rescue reloads the counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_r        <= 1'b0;
            busy_cnt_r    <= {CNT_W{1'b0}};
            rescue_done_r <= 1'b0;
            fsr_ready_r   <= FSR_RESET[7];
        end else begin
            rescue_done_r <= 1'b0;
            if (p2_hit_s) begin
                busy_r      <= 1'b1;
                busy_cnt_r  <= BUSY_LOAD;
                fsr_ready_r <= 1'b0;
            end else if (busy_r) begin
                if (busy_cnt_r == {CNT_W{1'b0}}) begin
                    busy_r        <= 1'b0;
                    rescue_done_r <= 1'b1;
                    fsr_ready_r   <= 1'b1;
                end else begin
                    busy_cnt_r <= busy_cnt_r - CNT_W'(1);
                end
            end
        end
    end

    assign spi_dq1_o     = dq1_r;
    assign spi_dq1_oe_o  = dq1_oe_r;
    assign rescue_done_o = rescue_done_r;
    assign busy_o        = busy_r;

endmodule

// File: tb/tb_flash_cmd_responder.sv
// Directed bench for flash_cmd_responder: FSR reads, rescue sequence
// acceptance/rejection, busy timing and reset during busy.
module tb_flash_cmd_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sck = 1'b0;
    logic cs_n = 1'b1;
    logic dq0 = 1'b0;
    logic dq1;
    logic dq1_oe;
    logic done;
    logic busy;

    int n_cmp = 0;
    int n_mis = 0;

    int cyc = 0;
    int t_busy = 0;
    int t_done = 0;
    int done_cnt = 0;
    logic busy_q = 1'b0;

    flash_cmd_responder #(.RESCUE_CYCLES(2000), .FSR_RESET(8'h80)) dut (
        .clk_i(clk), .rst_i(rst), .spi_sck_i(sck), .spi_cs_ni(cs_n),
        .spi_dq0_i(dq0), .spi_dq1_o(dq1), .spi_dq1_oe_o(dq1_oe),
        .rescue_done_o(done), .busy_o(busy)
    );

    always #5 clk = ~clk;

    // Free-running cycle count.
    always @(posedge clk) cyc <= cyc + 1;

    // Records busy rise and rescue_done pulses, sampled away from the clock edge.
    always @(negedge clk) begin
        busy_q <= busy;
        if (!rst) begin
            if (busy && !busy_q) t_busy <= cyc;
            if (done) begin
                t_done   <= cyc;
                done_cnt <= done_cnt + 1;
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        wait_clk(8);
    endtask

    task automatic cs_high();
        wait_clk(8);
        cs_n = 1'b1;
        dq0  = 1'b0;
        wait_clk(8);
    endtask

    task automatic send_bits(input logic [31:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            dq0 = val[i];
            wait_clk(8);
            sck = 1'b1;
            wait_clk(8);
            sck = 1'b0;
        end
    endtask

    task automatic frame_ones(input int n);
        cs_low();
        send_bits(32'hFFFF_FFFF, n);
        cs_high();
    endtask

    task automatic read_byte(output logic [7:0] b, output logic oe_all);
        oe_all = 1'b1;
        b      = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            wait_clk(8);
            b[i]   = dq1;
            oe_all = oe_all & dq1_oe;
            sck = 1'b1;
            wait_clk(8);
            sck = 1'b0;
        end
    endtask

    task automatic read_fsr(output logic [7:0] b);
        logic oe_all;
        cs_low();
        send_bits(32'h70, 8);
        read_byte(b, oe_all);
        cs_high();
    endtask

    task automatic rescue_seq();
        frame_ones(7);
        frame_ones(13);
        frame_ones(25);
        frame_ones(8);
    endtask

    initial begin
        logic [7:0] b;
        logic oe_all;
        int d0;
        int k;

        // Reset state
        wait_clk(3);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_done", {31'd0, done}, 32'd0);
        check_val("rst_oe", {31'd0, dq1_oe}, 32'd0);
        check_val("rst_dq1", {31'd0, dq1}, 32'd0);
        rst = 1'b0;
        wait_clk(10);

        // Single FSR read
        cs_low();
        send_bits(32'h7, 4);
        check_val("cmd_oe_low", {31'd0, dq1_oe}, 32'd0);
        send_bits(32'h0, 4);
        read_byte(b, oe_all);
        check_val("fsr_read", {24'd0, b}, 32'h80);
        check_val("fsr_oe_high", {31'd0, oe_all}, 32'd1);
        cs_high();
        check_val("idle_oe_low", {31'd0, dq1_oe}, 32'd0);

        // FSR repeated while CS stays low
        cs_low();
        send_bits(32'h70, 8);
        for (int r = 0; r < 3; r++) begin
            read_byte(b, oe_all);
            check_val($sformatf("fsr_rep%0d", r), {24'd0, b}, 32'h80);
        end
        cs_high();

        // Part-1 one bit short: no busy
        frame_ones(6);
        frame_ones(8);
        wait_clk(10);
        check_val("short_p1_busy", {31'd0, busy}, 32'd0);

        // Other command between parts clears arming
        frame_ones(7);
        frame_ones(13);
        frame_ones(25);
        cs_low();
        send_bits(32'h05, 8);
        cs_high();
        frame_ones(8);
        wait_clk(10);
        check_val("disarm_busy", {31'd0, busy}, 32'd0);

        // Full rescue sequence
        d0 = done_cnt;
        rescue_seq();
        check_val("rescue_busy", {31'd0, busy}, 32'd1);
        read_fsr(b);
        check_val("busy_fsr", {24'd0, b}, 32'h00);
        k = 0;
        while (done_cnt == d0 && k < 3000) begin
            wait_clk(1);
            k++;
        end
        check_val("done_seen", {31'd0, (done_cnt != d0)}, 32'd1);
        wait_clk(5);
        check_val("done_pulses", done_cnt - d0, 32'd1);
        check_val("busy_len", t_done - t_busy, 32'd2000);
        check_val("post_busy", {31'd0, busy}, 32'd0);
        read_fsr(b);
        check_val("ready_fsr", {24'd0, b}, 32'h80);

        // Reset in the middle of the busy period
        rescue_seq();
        check_val("rescue2_busy", {31'd0, busy}, 32'd1);
        wait_clk(100);
        d0 = done_cnt;
        rst = 1'b1;
        #1;
        check_val("rst_busy_clr", {31'd0, busy}, 32'd0);
        wait_clk(3);
        rst = 1'b0;
        wait_clk(2100);
        check_val("rst_no_done", done_cnt - d0, 32'd0);
        check_val("rst_still_idle", {31'd0, busy}, 32'd0);
        read_fsr(b);
        check_val("rst_fsr", {24'd0, b}, 32'h80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/flash_cmd_responder.md
FLASH_CMD_RESPONDER -- requirements
Module: flash_cmd_responder

Interface
REQ-001 SHALL have parameter RESCUE_CYCLES, default 2000: clk_i cycles the block stays busy after a completed power-loss rescue sequence.
REQ-002 SHALL have parameter FSR_RESET, default 8'h80: flag status register (FSR) value after reset.
REQ-003 SHALL have port clk_i, input, 1: single system clock; all logic runs in this domain.
REQ-004 SHALL have port rst_i, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port spi_sck_i, input, 1: SPI clock, asynchronous to clk_i.
REQ-006 SHALL have port spi_cs_ni, input, 1: chip select S, active-low.
REQ-007 SHALL have port spi_dq0_i, input, 1: serial data in (host to device).
REQ-008 SHALL have port spi_dq1_o, output, 1: serial data out (device to host).
REQ-009 SHALL have port spi_dq1_oe_o, output, 1: drive enable for spi_dq1_o.
REQ-010 SHALL have port rescue_done_o, output, 1: one-cycle pulse when the rescue busy period ends.
REQ-011 SHALL have port busy_o, output, 1: high while the rescue busy period is active.

Function
REQ-012 SHALL pass spi_sck_i, spi_cs_ni and spi_dq0_i through 2-flop synchronizers, then detect SCK rising and falling edges in the clk_i domain (3-cycle input latency).
REQ-013 SHALL implement FSM states IDLE, CMD, FSR_OUT, IGNORE.
REQ-014 IDLE -> CMD on synchronized CS falling edge; bit counter and shift register cleared.
REQ-015 In CMD, SHALL shift DQ0 MSB-first into an 8-bit register on each SCK rising edge, counting bits with a 5-bit saturating counter (saturates at 31).
REQ-016 On the 8th bit in CMD, if opcode == 8'h70 SHALL go to FSR_OUT; otherwise SHALL stay in CMD and keep counting, for rescue detection.
REQ-017 In FSR_OUT, SHALL drive spi_dq1_oe_o=1 and shift the FSR out MSB-first on SCK falling edges; after bit 0, SHALL wrap and resend the FSR while CS stays low.
REQ-018 In CMD, SHALL track an all_ones flag: set at frame start, cleared by any 0 sampled on DQ0.
REQ-019 On CS rising edge in CMD with all_ones=1: bit count 7, 13 or 25 -> SHALL set rescue_armed; bit count exactly 8 with rescue_armed=1 -> SHALL start the busy period and clear rescue_armed.
REQ-020 On any other CS rising edge outcome (non-1 data, other count, or completed command), SHALL clear rescue_armed; every CS rising edge SHALL return the FSM to IDLE.
REQ-021 IGNORE SHALL be entered when CS falls while busy_o=1; DQ1 stays tri-stated except for opcode 8'h70, which SHALL still be answered.
REQ-022 While busy: FSR[7] (ready) SHALL read 0 and a down-counter SHALL load RESCUE_CYCLES-1; when it reaches 0, SHALL set FSR[7]=1, deassert busy_o, and pulse rescue_done_o.
REQ-023 A rescue sequence completing while already busy SHALL reload the counter.
REQ-024 spi_dq1_oe_o SHALL be 0 in every state other than FSR_OUT.

Reset
REQ-025 On rst_i: FSM=IDLE, FSR=FSR_RESET, rescue_armed=0, busy_o=0, rescue_done_o=0, spi_dq1_o=0, spi_dq1_oe_o=0, counters and synchronizers cleared (CS synchronizer reset to 1).
REQ-026 Reset asserted mid-frame or mid-busy SHALL abort immediately; the next frame SHALL be decoded only after a fresh CS falling edge.

Structure
REQ-027 Opcode 8'h70, rescue part-1 lengths {7,13,25}, part-2 length 8, and the state enum SHALL live in shared package flash_resp_pkg.
REQ-028 Synchronizer and edge detection SHALL be one sub-module, spi_edge_sync, instantiated once per input.

Verification
REQ-029 Send 0x70 then 8 SCKs -> DQ1 returns 8'h80, oe high during data bits only.
REQ-030 Send 7 ones + CS high, 13 ones + CS high, 25 ones + CS high, 8 ones + CS high -> busy_o high; FSR read returns 8'h00; after 2000 cycles rescue_done_o pulses and FSR read returns 8'h80.
REQ-031 Send 6 ones (one fewer than 7) + CS high, then 8 ones -> no busy.
REQ-032 Send part1 sequence, then 0x05 command, then 8 ones -> rescue_armed cleared, no busy.
REQ-033 Send 0x70 and hold CS for 24 SCKs -> FSR repeated 3 times.
REQ-034 Assert rst_i midway through busy -> busy_o=0 immediately, FSR=8'h80, no rescue_done_o pulse.
